vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Shares one single-port 8-bit framebuffer RAM (160x120 pixels, RGB332) between VGA scanout and a drawing writer. It also sequences a full-screen clear. The block sits between the VGA timing generator and the DAC pins. It upscales each framebuffer pixel 4x4 onto the 640x480 display and delays the sync and blank signals so they stay aligned with the pixel data.

## Interface
Parameters:
- LAT, 3: pipeline depth from input coordinates to VGA pins; fixed by the RAM read latency.
- FB_W, 160: framebuffer width in pixels.
- FB_H, 120: framebuffer height in pixels.

Ports:
- vga_clk  in  1  pixel clock, 25 MHz; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- pix_x  in  10  display column from the timing generator, 0..639 while active.
- pix_y  in  10  display row, 0..479 while active.
- hs_in, vs_in, blank_n_in  in  1 each  timing generator outputs, aligned with pix_x and pix_y.
- wr_valid  in  1  draw request.
- wr_ready  out  1  draw request accepted this cycle when wr_valid is also high.
- wr_x  in  8  framebuffer column.
- wr_y  in  7  framebuffer row.
- wr_data  in  8  RGB332 pixel value.
- clr_start  in  1  one-cycle pulse that starts a clear.
- clr_color  in  8  clear value; sampled when clr_start is accepted.
- clr_busy  out  1  high while a clear is in progress.
- mem_addr  out  15  RAM address, registered.
- mem_we  out  1  RAM write enable, registered.
- mem_wdata  out  8  RAM write data, registered.
- mem_rdata  in  8  RAM read data; synchronous RAM, valid one cycle after mem_addr.
- VGA_HS, VGA_VS, VGA_BLANK_N  out  1 each  timing inputs delayed by LAT cycles.
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour.

## Operation
- **Display slot:** a cycle where blank_n_in is 1 and pix_x[1:0] is 0.
  - Issue a read with mem_addr = (pix_y>>2)*160 + (pix_x>>2) and mem_we = 0.
  - Compute the multiply as (y<<7)+(y<<5) in 15 bits; the maximum address is 19199.
- **Other cycles:** all non-slot cycles, including the whole of blanking, belong to the writer or the clear sequencer.
- **States:** IDLE and CLEAR.
- **IDLE:**
  - wr_ready = !disp_slot && !clr_start; this is combinational.
  - When a write is accepted and wr_x < 160 and wr_y < 120: mem_we = 1, mem_addr = wr_y*160 + wr_x, mem_wdata = wr_data.
  - Out-of-range writes are accepted and dropped (mem_we stays 0).
- **IDLE to CLEAR:** on clr_start, whatever the slot state.
  - Latch clr_color.
  - Set the clear counter to 0 and clr_busy to 1.
  - A write presented in the same cycle is not accepted.
- **CLEAR:**
  - wr_ready = 0.
  - On each non-slot cycle, write the latched colour to address = counter, then increment the counter.
  - Display slots still read normally.
  - After writing address 19199, return to IDLE; clr_busy falls in that same transition.
  - clr_start during CLEAR is ignored.
- **Pixel register:** loads mem_rdata only for data returning from a display read, so each pixel holds for 4 cycles.
- **Colour:** expand RGB332 as R = {r[2:0], r[2:0], r[2:1]}, G = {g[2:0], g[2:0], g[2:1]}, B = {b[1:0] repeated 4 times}.
- **Blanking:** RGB outputs are 0 whenever the delayed blank_n is 0.

## Timing
- **Display read pipeline:**
  - Decision in cycle t, from the inputs sampled at cycle t.
  - mem_addr is valid in cycle t+1.
  - mem_rdata is valid in cycle t+2.
  - RGB appears in cycle t+3.
- hs_in, vs_in and blank_n_in pass through a LAT = 3 stage delay, so VGA outputs stay aligned with the RGB.
- **Writes:** accepted in cycle t, mem_we pulses in cycle t+1, one cycle wide.
- Back-to-back writes are supported: up to 3 accepted in every 4 active cycles, and 1 per cycle in blanking.
- **Clear duration:** 19200 non-slot cycles; no more than one frame at 640x480.
- **Reset values:**
  - State IDLE; clr_busy = 0.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - Pixel register = 0; RGB = 0.
  - VGA_HS = 1, VGA_VS = 1, VGA_BLANK_N = 0.
  - Delay stages reset to the same values.
- **Reset during CLEAR:** abandons the clear immediately; no further writes.

## Structure
- **Package vga_fb_pkg:**
  - FB_W, FB_H, FB_WORDS = 19200, ADDR_W = 15.
  - State enum {IDLE, CLEAR}.
  - Function rgb332_expand.
  - Function fb_addr(x, y).
- **Sub-module vga_sync_delay:** a LAT-deep shift register for hs, vs and blank_n, with reset values 1, 1, 0.

## Test plan
- **Reset:**
  - Stimulus: assert reset_n = 0 mid-line.
  - Required: mem_we = 0, RGB = 0, VGA_HS = VGA_VS = 1, clr_busy = 0 until release.
- **Scanout:**
  - Stimulus: the RAM model returns 8'hE0 at address 161; the timing generator reaches pix_y = 4, pix_x = 4.
  - Required: mem_addr = 161 one cycle later; RGB = (FF, 00, 00) for cycles +3 to +6.
- **Writer arbitration:**
  - Stimulus: wr_valid held high across an active line.
  - Required: wr_ready = 0 on every cycle with pix_x[1:0] = 0; exactly 3 writes per 4 cycles.
- **Range drop:**
  - Stimulus: write at wr_x = 160, then at wr_x = 159, wr_y = 119.
  - Required: the first write is accepted with no mem_we; the second gives mem_we with mem_addr = 19199.
- **Clear:**
  - Stimulus: clr_start with clr_color = 8'h1C, while wr_valid = 1 in the same cycle.
  - Required: that write is not accepted; 19200 writes of 1C to addresses 0..19199 in order; clr_busy falls after the last; a second clr_start mid-clear has no effect.
- **Reset mid-clear:**
  - Stimulus: assert reset_n at counter = 5000.
  - Required: state IDLE, no further mem_we.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared definitions for the VGA framebuffer arbiter:
// framebuffer geometry, the arbiter state type and the pixel helpers.
package vga_fb_pkg;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_WORDS = 19200;
  localparam int ADDR_W   = 15;

  // IDLE serves the drawing writer; CLEAR walks the whole framebuffer.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // One 24-bit DAC colour.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // RGB332 to 8:8:8 by bit replication, so full-scale stays full-scale.
  function automatic rgb_t rgb332_expand(input logic [7:0] p);
    rgb_t c;
    c.r = {p[7:5], p[7:5], p[7:6]};
    c.g = {p[4:2], p[4:2], p[4:3]};
    c.b = {4{p[1:0]}};
    return c;
  endfunction

  // Linear framebuffer address y*160 + x, with the multiply done as two shifts.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [7:0] y);
    logic [ADDR_W-1:0] w_x15;
    logic [ADDR_W-1:0] w_y15;
    w_x15 = {7'd0, x};
    w_y15 = {7'd0, y};
    return (w_y15 << 7) + (w_y15 << 5) + w_x15;
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_sync_delay.sv
// Delays hs / vs / blank_n by LAT clocks so they line up with pixel data
// coming out of the framebuffer read pipeline.
module vga_sync_delay #(
  parameter int LAT = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_hs,
  input  logic i_vs,
  input  logic i_blank_n,
  output logic o_hs,
  output logic o_vs,
  output logic o_blank_n
);

  // Each stage packs {hs, vs, blank_n}; idle-level syncs, blanked video.
  localparam logic [2:0] STAGE_RST = 3'b110;

  logic [2:0] r_stage [0:LAT-1];
  logic [2:0] w_stage_in;

  assign w_stage_in = {i_hs, i_vs, i_blank_n};

  // Shift the timing signals down the delay line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        r_stage[i] <= STAGE_RST;
      end
    end else begin
      r_stage[0] <= w_stage_in;
      for (int i = 1; i < LAT; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_hs      = r_stage[LAT-1][2];
  assign o_vs      = r_stage[LAT-1][1];
  assign o_blank_n = r_stage[LAT-1][0];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout reads take every fourth active
// pixel clock, all remaining cycles go to the drawing writer or to the
// full-screen clear sequencer. Pixels are upscaled 4x4 and the timing
// signals are delayed to match the RAM read latency.
module vga_fb_arbiter #(
  parameter int LAT  = 3,
  parameter int FB_W = 160,
  parameter int FB_H = 120
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        blank_n_in,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_x,
  input  logic [6:0]  wr_y,
  input  logic [7:0]  wr_data,
  input  logic        clr_start,
  input  logic [7:0]  clr_color,
  output logic        clr_busy,
  output logic [14:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
);

  import vga_fb_pkg::*;

  localparam logic [7:0]        FB_W_L    = 8'(FB_W);
  localparam logic [6:0]        FB_H_L    = 7'(FB_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              w_disp_slot;
  logic              w_wr_ready;
  logic              w_clr_busy;
  logic              w_clr_write;
  logic              w_wr_fire;
  logic              w_wr_in_range;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [7:0]        r_clr_color;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [7:0]        r_mem_wdata;
  logic [1:0]        r_rd_pipe;
  logic [7:0]        r_pixel;
  logic              w_hs_d;
  logic              w_vs_d;
  logic              w_blank_d;
  rgb_t              w_rgb;
  logic              w_unused_pix_y;

  // Each framebuffer pixel covers 4 display columns, so one read per group.
  assign w_disp_slot = blank_n_in && (pix_x[1:0] == 2'b00);

  // Sub-pixel row bits select nothing: a framebuffer row spans 4 lines.
  assign w_unused_pix_y = ^pix_y[1:0];

  assign w_rd_addr     = fb_addr(pix_x[9:2], pix_y[9:2]);
  assign w_wr_addr     = fb_addr(wr_x, {1'b0, wr_y});
  assign w_wr_in_range = (wr_x < FB_W_L) && (wr_y < FB_H_L);
  assign w_wr_fire     = wr_valid && w_wr_ready;

  // State register.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: a clear runs until the last address has been written.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (clr_start) begin
          w_state_next = CLEAR;
        end
      end
      CLEAR: begin
        if (!w_disp_slot && (r_clr_cnt == LAST_ADDR)) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State outputs: who owns the non-display cycles.
  always_comb begin
    w_wr_ready  = 1'b0;
    w_clr_busy  = 1'b0;
    w_clr_write = 1'b0;
    case (r_state)
      IDLE: begin
        // A clear request wins over a write presented in the same cycle.
        w_wr_ready = !w_disp_slot && !clr_start;
      end
      CLEAR: begin
        w_clr_busy  = 1'b1;
        w_clr_write = !w_disp_slot;
      end
      default: begin
        w_wr_ready = 1'b0;
      end
    endcase
  end

  assign wr_ready = w_wr_ready;
  assign clr_busy = w_clr_busy;

  // Clear sequencer: latch colour on start, step the address on each write.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clr_cnt   <= '0;
      r_clr_color <= '0;
    end else if ((r_state == IDLE) && clr_start) begin
      r_clr_cnt   <= '0;
      r_clr_color <= clr_color;
    end else if (w_clr_write) begin
      r_clr_cnt   <= r_clr_cnt + 1'b1;
    end
  end

  // RAM port: display read has priority, then clear, then the writer.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_disp_slot) begin
        r_mem_addr <= w_rd_addr;
      end else if (w_clr_write) begin
        r_mem_addr  <= r_clr_cnt;
        r_mem_we    <= 1'b1;
        r_mem_wdata <= r_clr_color;
      end else if (w_wr_fire && w_wr_in_range) begin
        r_mem_addr  <= w_wr_addr;
        r_mem_we    <= 1'b1;
        r_mem_wdata <= wr_data;
      end
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;

  // Track display reads so only their data reaches the pixel register.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_pipe <= 2'b00;
    end else begin
      r_rd_pipe <= {r_rd_pipe[0], w_disp_slot};
    end
  end

  // Pixel register holds one framebuffer pixel for its 4 display columns.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pixel <= '0;
    end else if (r_rd_pipe[1]) begin
      r_pixel <= mem_rdata;
    end
  end

  vga_sync_delay #(
    .LAT (LAT)
  ) u_sync_delay (
    .i_clk     (vga_clk),
    .i_rst_n   (reset_n),
    .i_hs      (hs_in),
    .i_vs      (vs_in),
    .i_blank_n (blank_n_in),
    .o_hs      (w_hs_d),
    .o_vs      (w_vs_d),
    .o_blank_n (w_blank_d)
  );

  assign w_rgb = rgb332_expand(r_pixel);

  assign VGA_HS      = w_hs_d;
  assign VGA_VS      = w_vs_d;
  assign VGA_BLANK_N = w_blank_d;
  assign VGA_R       = w_blank_d ? w_rgb.r : 8'h00;
  assign VGA_G       = w_blank_d ? w_rgb.g : 8'h00;
  assign VGA_B       = w_blank_d ? w_rgb.b : 8'h00;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: a behavioural RAM, a framebuffer shadow and a
// cycle-level model of who owns each cycle; every cycle is checked.
module tb_vga_fb_arbiter;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  pix_x = '0, pix_y = '0;
  logic        hs_in = 1'b1, vs_in = 1'b1, blank_n_in = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  wr_x = '0;
  logic [6:0]  wr_y = '0;
  logic [7:0]  wr_data = '0;
  logic        clr_start = 1'b0;
  logic [7:0]  clr_color = '0;
  logic        clr_busy;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  always #5 vga_clk = ~vga_clk;

  vga_fb_arbiter dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .pix_x(pix_x), .pix_y(pix_y),
    .hs_in(hs_in), .vs_in(vs_in), .blank_n_in(blank_n_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .clr_start(clr_start), .clr_color(clr_color),
    .clr_busy(clr_busy), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  // Synchronous single-port RAM, read-before-write.
  logic [7:0] ram [0:19199];
  always @(posedge vga_clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model state.
  logic [7:0] shadow [0:19199];
  bit         m_clear;
  int         m_cnt;
  logic [7:0] m_color;
  logic [7:0] m_pix;
  bit         pend_valid;
  int         pend_addr;
  logic [7:0] pend_old;

  typedef struct {
    logic        hs;
    logic        vs;
    logic        bn;
    logic [23:0] rgb;
  } vexp_t;
  vexp_t vq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int n_clr_we;

  function automatic logic [23:0] expand(input logic [7:0] v);
    int r, g, b;
    logic [7:0] rr, gg, bb;
    r  = v / 32;
    g  = (v / 4) % 8;
    b  = v % 4;
    rr = 8'((r * 32) + (r * 4) + (r / 2));
    gg = 8'((g * 32) + (g * 4) + (g / 2));
    bb = 8'(b * 85);
    return {rr, gg, bb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus with full checking against the model.
  task automatic cyc(input logic bl, input int px, input int py, input logic wv,
                     input int wx, input int wy, input logic [7:0] wd,
                     input logic cs, input logic [7:0] cc);
    bit    slot, exp_ready, acc, was_clear, e_we, chk_addr;
    int    e_addr;
    logic [7:0] e_data;
    vexp_t e, o;
    blank_n_in = bl;
    pix_x = 10'(px);
    pix_y = 10'(py);
    hs_in = 1'($urandom_range(0, 1));
    vs_in = 1'($urandom_range(0, 1));
    wr_valid = wv;
    wr_x = 8'(wx);
    wr_y = 7'(wy);
    wr_data = wd;
    clr_start = cs;
    clr_color = cc;
    #1;
    was_clear = m_clear;
    slot      = bl && (px % 4 == 0);
    exp_ready = !was_clear && !slot && !cs;
    chk("wr_ready", wr_ready, exp_ready);
    chk("clr_busy", clr_busy, was_clear);
    acc = wv && exp_ready;
    if (acc) n_acc++;
    e_we = 0; chk_addr = 0; e_addr = 0; e_data = 0;
    pend_valid = 0;
    if (slot) begin
      e_addr = (py / 4) * 160 + (px / 4);
      chk_addr = 1;
      m_pix = shadow[e_addr];
    end else if (was_clear) begin
      e_we = 1; e_addr = m_cnt; e_data = m_color;
      m_cnt++;
      if (m_cnt == 19200) m_clear = 0;
    end else if (acc && wx < 160 && wy < 120) begin
      e_we = 1; e_addr = wy * 160 + wx; e_data = wd;
    end
    if (e_we) begin
      pend_valid = 1; pend_addr = e_addr; pend_old = shadow[e_addr];
      shadow[e_addr] = e_data;
      chk_addr = 1;
    end
    if (!was_clear && cs) begin
      m_clear = 1; m_cnt = 0; m_color = cc;
    end
    e.hs = hs_in; e.vs = vs_in; e.bn = bl;
    e.rgb = bl ? expand(m_pix) : 24'h0;
    vq.push_back(e);
    @(posedge vga_clk);
    #1;
    chk("mem_we", mem_we, e_we);
    if (chk_addr) chk("mem_addr", mem_addr, e_addr);
    if (e_we) chk("mem_wdata", mem_wdata, e_data);
    if (vq.size() >= 3) begin
      o = vq.pop_front();
      chk("vga_hs", VGA_HS, o.hs);
      chk("vga_vs", VGA_VS, o.vs);
      chk("vga_blank_n", VGA_BLANK_N, o.bn);
      chk("vga_rgb", {VGA_R, VGA_G, VGA_B}, o.rgb);
    end
  endtask

  // Hold reset for n clocks with busy inputs, checking the reset outputs.
  task automatic do_reset(input int n);
    vexp_t r;
    reset_n = 1'b0;
    #1;
    // A write registered but not yet clocked into the RAM is lost.
    if (pend_valid) shadow[pend_addr] = pend_old;
    pend_valid = 0;
    for (int i = 0; i < n; i++) begin
      blank_n_in = 1'($urandom_range(0, 1));
      pix_x = 10'($urandom_range(0, 639));
      wr_valid = 1'b1;
      clr_start = 1'b1;
      #1;
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 15'd0);
      chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
      chk("rst_hs", VGA_HS, 1'b1);
      chk("rst_vs", VGA_VS, 1'b1);
      chk("rst_blank_n", VGA_BLANK_N, 1'b0);
      chk("rst_clr_busy", clr_busy, 1'b0);
      @(posedge vga_clk);
      #1;
    end
    m_clear = 0; m_cnt = 0; m_pix = 8'h00;
    vq.delete();
    r.hs = 1'b1; r.vs = 1'b1; r.bn = 1'b0; r.rgb = 24'h0;
    vq.push_back(r);
    vq.push_back(r);
    wr_valid = 1'b0;
    clr_start = 1'b0;
    blank_n_in = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    int h, py;
    for (int a = 0; a < 19200; a++) begin
      ram[a] = 8'($urandom);
      shadow[a] = ram[a];
    end
    m_clear = 0; m_cnt = 0; m_color = 0; m_pix = 0; pend_valid = 0;
    @(posedge vga_clk);
    #1;
    do_reset(3);

    // Scanout: framebuffer (1,1) = E0 shows as pure red at display (4,4).
    cyc(1'b0, 700, 4, 1'b1, 1, 1, 8'hE0, 1'b0, 8'h00);
    for (int px = 0; px < 16; px++) begin
      cyc(1'b1, px, 4, 1'b0, 0, 0, 8'h00, 1'b0, 8'h00);
      if (px == 4) chk("scan_addr", mem_addr, 15'd161);
      if (px >= 6 && px <= 9) chk("scan_rgb", {VGA_R, VGA_G, VGA_B}, 24'hFF0000);
    end

    // Writer arbitration across a full active line.
    n_acc = 0;
    for (int px = 0; px < 640; px++) begin
      cyc(1'b1, px, 8, 1'b1, $urandom_range(0, 159), $urandom_range(0, 119),
          8'($urandom), 1'b0, 8'h00);
    end
    chk("arb_accepts", n_acc, 480);

    // Range drop and last-address write.
    cyc(1'b0, 700, 8, 1'b1, 160, 5, 8'hAA, 1'b0, 8'h00);
    chk("drop_we", mem_we, 1'b0);
    cyc(1'b0, 700, 8, 1'b1, 159, 119, 8'h55, 1'b0, 8'h00);
    chk("edge_we", mem_we, 1'b1);
    chk("edge_addr", mem_addr, 15'd19199);

    // Random traffic over scanlines, with a reset in the middle of a line.
    h = 0; py = $urandom_range(0, 479);
    for (int i = 0; i < 1200; i++) begin
      if (i == 400) do_reset(2);
      cyc(1'(h < 640), h, py, 1'($urandom_range(0, 1)), $urandom_range(0, 175),
          $urandom_range(0, 127), 8'($urandom), 1'b0, 8'h00);
      h = (h + 1) % 800;
      if (h == 0) py = $urandom_range(0, 479);
    end

    // Full clear, started on a display slot with a competing write.
    cyc(1'b1, 0, 12, 1'b1, 3, 3, 8'h77, 1'b1, 8'h1C);
    n_clr_we = 0;
    for (int i = 0; i < 40000 && m_clear; i++) begin
      cyc(1'($urandom_range(0, 3) == 0), i % 640, $urandom_range(0, 479),
          1'($urandom_range(0, 1)), $urandom_range(0, 159), $urandom_range(0, 119),
          8'($urandom), 1'(i == 1000), 8'hE3);
      if (mem_we) n_clr_we++;
    end
    chk("clr_writes", n_clr_we, 19200);
    chk("clr_done_busy", clr_busy, 1'b0);
    for (int px = 0; px < 40; px++) begin
      cyc(1'b1, px, 40, 1'b0, 0, 0, 8'h00, 1'b0, 8'h00);
    end

    // Reset in the middle of a clear.
    cyc(1'b0, 700, 0, 1'b0, 0, 0, 8'h00, 1'b1, 8'h5A);
    for (int i = 0; i < 6000 && m_cnt < 5000; i++) begin
      cyc(1'b0, 700, 0, 1'b0, 0, 0, 8'h00, 1'b0, 8'h00);
    end
    chk("clr_cnt_at_reset", m_cnt, 5000);
    do_reset(2);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 700, 0, 1'b0, 0, 0, 8'h00, 1'b0, 8'h00);
      chk("post_rst_we", mem_we, 1'b0);
    end
    chk("post_rst_busy", clr_busy, 1'b0);
    for (int px = 0; px < 64; px++) begin
      cyc(1'b1, px, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 159),
          $urandom_range(0, 119), 8'($urandom), 1'b0, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
